// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session controller: lock/active/exec FSM with balance, session withdraw limit and idle timeout
module atm_session_ctrl #(
    parameter logic [15:0] INIT_BALANCE = 16'd1000,
    parameter logic [15:0] WD_LIMIT     = 16'd500,
    parameter logic [7:0]  TIMEOUT_CYC  = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        unlock,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [15:0] amount,
    output logic        op_ready,
    output logic        session_active,
    output logic [15:0] balance,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        timeout
);

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        ACTIVE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    localparam logic [1:0] OP_QUERY    = 2'b00;
    localparam logic [1:0] OP_DEPOSIT  = 2'b01;
    localparam logic [1:0] OP_WITHDRAW = 2'b10;
    localparam logic [1:0] OP_LOGOUT   = 2'b11;

    localparam logic [1:0] ERR_FUNDS = 2'b01;
    localparam logic [1:0] ERR_LIMIT = 2'b10;
    localparam logic [1:0] ERR_OVF   = 2'b11;

    state_t      state;
    logic [7:0]  idle_cnt;
    logic [15:0] wd_total;
    logic [1:0]  op_q;
    logic [15:0] amt_q;
    logic [16:0] dep_sum;
    logic [16:0] wd_sum;

    // 17-bit sums so deposit overflow and session-limit checks see the carry
    assign dep_sum = {1'b0, balance} + {1'b0, amt_q};
    assign wd_sum  = {1'b0, wd_total} + {1'b0, amt_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= LOCKED;
            idle_cnt       <= 8'd0;
            wd_total       <= 16'd0;
            op_q           <= OP_QUERY;
            amt_q          <= 16'd0;
            op_ready       <= 1'b0;
            session_active <= 1'b0;
            balance        <= INIT_BALANCE;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= 2'b00;
            timeout        <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            case (state)
                LOCKED: begin
                    if (unlock) begin
                        state          <= ACTIVE;
                        idle_cnt       <= 8'd0;
                        wd_total       <= 16'd0;
                        op_ready       <= 1'b1;
                        session_active <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // A request arriving on the expiry cycle wins over the timeout
                    if (op_valid) begin
                        state    <= EXEC;
                        op_q     <= op_code;
                        amt_q    <= amount;
                        idle_cnt <= 8'd0;
                        op_ready <= 1'b0;
                    end else if (idle_cnt == TIMEOUT_CYC - 8'd1) begin
                        state          <= LOCKED;
                        timeout        <= 1'b1;
                        op_ready       <= 1'b0;
                        session_active <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                EXEC: begin
                    state    <= ACTIVE;
                    op_ready <= 1'b1;
                    case (op_q)
                        OP_DEPOSIT: begin
                            if (dep_sum[16]) begin
                                err      <= 1'b1;
                                err_code <= ERR_OVF;
                            end else begin
                                balance <= dep_sum[15:0];
                                done    <= 1'b1;
                            end
                        end
                        OP_WITHDRAW: begin
                            if (amt_q > balance) begin
                                err      <= 1'b1;
                                err_code <= ERR_FUNDS;
                            end else if (wd_sum > {1'b0, WD_LIMIT}) begin
                                err      <= 1'b1;
                                err_code <= ERR_LIMIT;
                            end else begin
                                balance  <= balance - amt_q;
                                wd_total <= wd_sum[15:0];
                                done     <= 1'b1;
                            end
                        end
                        OP_LOGOUT: begin
                            state          <= LOCKED;
                            op_ready       <= 1'b0;
                            session_active <= 1'b0;
                            done           <= 1'b1;
                        end
                        default: done <= 1'b1;
                    endcase
                end
                default: begin
                    state          <= LOCKED;
                    op_ready       <= 1'b0;
                    session_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - directed bench with a per-cycle behavioural model and literal checkpoints
module tb_atm_session_ctrl;

    localparam int INIT_BAL = 1000;
    localparam int LIMIT    = 500;
    localparam int TMO      = 200;
    localparam int M_LOCK   = 0;
    localparam int M_ACT    = 1;
    localparam int M_EXEC   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        unlock = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [15:0] amount = 16'd0;
    logic        op_ready;
    logic        session_active;
    logic [15:0] balance;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    atm_session_ctrl dut (
        .clk(clk), .rst(rst_n), .unlock(unlock), .op_valid(op_valid),
        .op_code(op_code), .amount(amount), .op_ready(op_ready),
        .session_active(session_active), .balance(balance), .done(done),
        .err(err), .err_code(err_code), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int mode;
        int bal;
        int total;
        int idle;
        int pcode;
        int pamt;
        int done;
        int err;
        int errc;
        int tmo;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '0;
        r.mode = M_LOCK;
        r.bal  = INIT_BAL;
        return r;
    endfunction

    // Session semantics from the account rules, using unbounded integer arithmetic
    function automatic mdl_t step(mdl_t c, logic u, logic v, logic [1:0] oc, logic [15:0] a);
        mdl_t n;
        n = c;
        n.done = 0;
        n.err  = 0;
        n.tmo  = 0;
        if (c.mode == M_LOCK) begin
            if (u) begin
                n.mode = M_ACT; n.idle = 0; n.total = 0;
            end
        end else if (c.mode == M_ACT) begin
            if (v) begin
                n.mode = M_EXEC; n.pcode = int'(oc); n.pamt = int'(a); n.idle = 0;
            end else if (c.idle + 1 == TMO) begin
                n.mode = M_LOCK; n.tmo = 1;
            end else begin
                n.idle = c.idle + 1;
            end
        end else begin
            n.mode = M_ACT;
            if (c.pcode == 1) begin
                if (c.bal + c.pamt > 65535) begin n.err = 1; n.errc = 3; end
                else begin n.bal = c.bal + c.pamt; n.done = 1; end
            end else if (c.pcode == 2) begin
                if (c.pamt > c.bal) begin n.err = 1; n.errc = 1; end
                else if (c.total + c.pamt > LIMIT) begin n.err = 1; n.errc = 2; end
                else begin n.bal = c.bal - c.pamt; n.total = c.total + c.pamt; n.done = 1; end
            end else if (c.pcode == 3) begin
                n.mode = M_LOCK; n.done = 1;
            end else begin
                n.done = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= step(m, unlock, op_valid, op_code, amount);
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("op_ready",       int'(op_ready),       int'(m.mode == M_ACT));
        cmp("session_active", int'(session_active), int'(m.mode != M_LOCK));
        cmp("balance",        int'(balance),        m.bal);
        cmp("done",           int'(done),           m.done);
        cmp("err",            int'(err),            m.err);
        cmp("err_code",       int'(err_code),       m.errc);
        cmp("timeout",        int'(timeout),        m.tmo);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_unlock();
        unlock = 1'b1;
        tick();
        unlock = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] c, input int a);
        op_valid = 1'b1;
        op_code  = c;
        amount   = 16'(a);
        tick();
        op_valid = 1'b0;
        tick();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        cmp("rst_balance", int'(balance), 1000);
        cmp("rst_op_ready", int'(op_ready), 0);
        cmp("rst_err_code", int'(err_code), 0);
        rst_n = 1'b1;

        // op_valid while locked has no effect
        do_op(2'b10, 300);
        cmp("locked_ignore_bal", int'(balance), 1000);
        cmp("locked_ignore_done", int'(done), 0);

        do_unlock();
        cmp("unlock_active", int'(session_active), 1);
        op_valid = 1'b1; op_code = 2'b10; amount = 16'd300;
        tick();
        op_valid = 1'b0;
        cmp("exec_ready_low", int'(op_ready), 0);
        cmp("exec_no_done", int'(done), 0);
        tick();
        cmp("wd300_done", int'(done), 1);
        cmp("wd300_bal", int'(balance), 700);
        cmp("wd300_ready", int'(op_ready), 1);

        do_op(2'b10, 250);
        cmp("limit_err", int'(err), 1);
        cmp("limit_code", int'(err_code), 2);
        cmp("limit_bal", int'(balance), 700);

        do_op(2'b11, 0);
        cmp("logout_done", int'(done), 1);
        cmp("logout_inactive", int'(session_active), 0);

        do_unlock();
        do_op(2'b10, 250);
        cmp("wd250_bal", int'(balance), 450);
        do_op(2'b10, 451);
        cmp("funds_code", int'(err_code), 1);
        cmp("funds_bal", int'(balance), 450);
        do_op(2'b10, 0);
        cmp("wd0_done", int'(done), 1);
        do_op(2'b01, 0);
        cmp("dep0_bal", int'(balance), 450);

        do_op(2'b01, 64550);
        cmp("dep_bal", int'(balance), 65000);
        do_op(2'b01, 600);
        cmp("ovf_code", int'(err_code), 3);
        cmp("ovf_bal", int'(balance), 65000);
        do_op(2'b01, 535);
        cmp("dep_max_bal", int'(balance), 65535);
        do_op(2'b00, 0);
        cmp("query_done", int'(done), 1);

        // unlock mid-session must not clear the 250 already withdrawn
        do_unlock();
        do_op(2'b10, 251);
        cmp("no_clear_code", int'(err_code), 2);
        do_op(2'b10, 250);
        cmp("limit_exact_bal", int'(balance), 65285);
        do_op(2'b11, 0);

        do_unlock();
        repeat (199) tick();
        cmp("pre_tmo_active", int'(session_active), 1);
        cmp("pre_tmo_flag", int'(timeout), 0);
        tick();
        cmp("tmo_flag", int'(timeout), 1);
        cmp("tmo_inactive", int'(session_active), 0);
        do_op(2'b01, 5);
        cmp("post_tmo_bal", int'(balance), 65285);

        do_unlock();
        repeat (199) tick();
        do_op(2'b00, 0);
        cmp("race_done", int'(done), 1);
        cmp("race_active", int'(session_active), 1);

        op_valid = 1'b1; op_code = 2'b01; amount = 16'd100;
        tick();
        op_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("exec_rst_bal", int'(balance), 1000);
        cmp("exec_rst_active", int'(session_active), 0);
        tick();
        cmp("exec_rst_done", int'(done), 0);
        rst_n = 1'b1;
        do_unlock();
        do_op(2'b00, 0);
        cmp("after_rst_done", int'(done), 1);
        cmp("after_rst_bal", int'(balance), 1000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 Parameter INIT_BALANCE, default 16'd1000, balance loaded at reset.
REQ-002 Parameter WD_LIMIT, default 16'd500, max total withdrawn per session.
REQ-003 Parameter TIMEOUT_CYC, default 8'd200, idle cycles in ACTIVE before forced lock.
REQ-004 clk  input  1  single clock, all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 unlock  input  1  one-cycle pulse from the PIN-entry FSM; opens a session.
REQ-007 op_valid  input  1  operation request valid.
REQ-008 op_code  input  2  00 balance query, 01 deposit, 10 withdraw, 11 logout.
REQ-009 amount  input  16  unsigned operand for deposit/withdraw; ignored otherwise.
REQ-010 op_ready  output  1  block can accept an operation this cycle.
REQ-011 session_active  output  1  high in ACTIVE or EXEC.
REQ-012 balance  output  16  registered account balance.
REQ-013 done  output  1  one-cycle pulse, operation completed successfully.
REQ-014 err  output  1  one-cycle pulse, operation rejected.
REQ-015 err_code  output  2  valid with err: 01 insufficient funds, 10 session limit, 11 overflow; holds last value otherwise.
REQ-016 timeout  output  1  one-cycle pulse when session closed by idle timer.

Function
REQ-017 States LOCKED, ACTIVE, EXEC shall exist; all outputs registered.
REQ-018 LOCKED: unlock=1 -> ACTIVE, idle timer and session withdraw total cleared to 0; else stay; op_valid ignored.
REQ-019 ACTIVE: op_ready=1; op_valid=1 -> latch op_code/amount, go EXEC, clear idle timer.
REQ-020 ACTIVE with op_valid=0: idle timer increments; when timer equals TIMEOUT_CYC-1 -> LOCKED with timeout pulse in the following cycle.
REQ-021 op_valid and timer expiry in same cycle: operation accepted, no timeout.
REQ-022 EXEC: op_ready=0; lasts exactly one cycle; then result applied, done or err pulse in next cycle.
REQ-023 Latency: op accepted at edge k; balance update and done/err visible after edge k+1; op_ready high again after edge k+1 (max one op per 2 cycles).
REQ-024 Balance query: done=1, balance unchanged.
REQ-025 Deposit: 17-bit sum balance+amount; bit16 set -> err, code 11, balance unchanged; else balance=sum, done.
REQ-026 Withdraw check order: amount>balance -> err code 01; else session_total+amount (17-bit) > WD_LIMIT -> err code 10; else balance-=amount, session_total+=amount, done.
REQ-027 Zero amount deposit/withdraw shall complete with done and no change.
REQ-028 Logout: done pulse, next state LOCKED, session_active low in same cycle as done.
REQ-029 unlock in ACTIVE or EXEC shall be ignored (no timer or total clear).
REQ-030 Balance persists across sessions; only rst restores INIT_BALANCE.
REQ-031 done, err, timeout mutually exclusive.

Reset
REQ-032 rst=0 shall immediately force LOCKED, balance=INIT_BALANCE, session total=0, timer=0, op_ready=0, session_active=0, done=err=timeout=0, err_code=00.
REQ-033 rst asserted during EXEC shall discard the pending operation without balance change beyond reset value.
REQ-034 After rst release, first unlock pulse shall open a session normally.

Verification
REQ-035 Reset, unlock, withdraw 300 -> done two edges after accept, balance 700, op_ready low one cycle.
REQ-036 Withdraw 300 then 250 in same session -> second gives err code 10, balance 700; logout, unlock, withdraw 250 -> done, balance 450.
REQ-037 Balance 450, withdraw 451 -> err code 01, balance 450.
REQ-038 Balance 65000 (via deposits), deposit 600 -> err code 11, balance unchanged; deposit 535 -> done, balance 65535.
REQ-039 Unlock, no op for 200 cycles -> timeout pulse, session_active low, subsequent op_valid ignored until next unlock.
REQ-040 rst pulse during EXEC of deposit 100 -> balance 1000, state LOCKED, no done/err.
